// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage (PC, memory req/ack, op valid/ready,
//            redirect, ack timeout with retry). Optional: OPCODE_CHECK_EN.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [7:0] RESET_ADDR  = 8'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] op,
    output logic        op_valid,
    input  logic        op_ready,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    output logic [7:0]  pc,
    output logic        fetch_err,
    output logic        illegal_op
);

    localparam int c_cnt_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_illegal;
    logic                 w_timeout;

`ifdef OPCODE_CHECK_EN
    assign w_illegal = (mem_rdata[31:27] > 5'd15);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            pc         <= RESET_ADDR;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_ADDR;
            op         <= 32'h0;
            op_valid   <= 1'b0;
            fetch_err  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            fetch_err  <= 1'b0;
            illegal_op <= 1'b0;
            if (redirect) begin
                // Any in-flight ack or timeout in this cycle is dropped.
                pc       <= redirect_addr;
                op_valid <= 1'b0;
                mem_req  <= 1'b0;
                r_cnt    <= '0;
                r_state  <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                        r_state  <= REQ;
                    end
                    REQ: begin
                        if (mem_ack) begin
                            op         <= w_illegal ? 32'h0 : mem_rdata;
                            illegal_op <= w_illegal;
                            op_valid   <= 1'b1;
                            pc         <= pc + 8'd1;
                            r_cnt      <= '0;
                            mem_req    <= 1'b0;
                            r_state    <= HOLD;
                        end else if (w_timeout) begin
                            fetch_err <= 1'b1;
                            r_cnt     <= '0;
                            mem_req   <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (op_ready) begin
                            op_valid <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            r_state  <= REQ;
                        end
                    end
                    default: begin
                        mem_req  <= 1'b0;
                        op_valid <= 1'b0;
                        r_state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control unit. Holds the 8-bit program counter, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents each word as op with a valid/ready handshake to decode. Supports PC redirect (jumps/branches) and recovers from an unresponsive memory through an ack timeout with retry.

Parameters:
RESET_ADDR, 8'h00, PC value loaded on reset.
ACK_TIMEOUT, 15, REQ cycles without mem_ack before the fetch is abandoned and retried; 0 disables the timeout.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
mem_req  out  1  fetch request to instruction memory
mem_addr  out  8  fetch address; equals pc while mem_req=1
mem_ack  in  1  memory returns mem_rdata this cycle; ends the transaction
mem_rdata  in  32  instruction word, sampled only when mem_req&mem_ack
op  out  32  instruction word to decode (opcode op[31:27])
op_valid  out  1  op holds a fetched, undelivered instruction
op_ready  in  1  decode accepts op this cycle
redirect  in  1  load redirect_addr into pc and flush
redirect_addr  in  8  new pc
pc  out  8  address of next word to fetch
fetch_err  out  1  one-cycle pulse on ack timeout
illegal_op  out  1  one-cycle pulse on illegal opcode (see Optional Feature); constant 0 otherwise

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: pc=RESET_ADDR, mem_req=0, mem_addr=RESET_ADDR, op=0, op_valid=0, fetch_err=0, illegal_op=0, timeout counter=0, state=IDLE. Reset mid-transaction discards any ack in that cycle.
- States: IDLE, REQ, HOLD.
- IDLE: mem_req=0, op_valid=0; always -> REQ next cycle. Entered after reset, after redirect, after timeout.
- REQ: mem_req=1, mem_addr=pc, held stable until ack. Ack allowed in first REQ cycle. On mem_ack: op<=mem_rdata, op_valid<=1, pc<=pc+1 (8-bit, 8'hFF wraps to 8'h00), counter<=0, -> HOLD. No ack: counter+1; if ACK_TIMEOUT!=0 and counter reaches ACK_TIMEOUT-1 with no ack this cycle: fetch_err=1 next cycle for one cycle, pc unchanged, -> IDLE (retry).
- HOLD: mem_req=0, op_valid=1, op stable. op_ready=1: op_valid<=0, -> REQ. op_ready=0: stay.
- Best-case throughput: one instruction per 2 cycles (REQ with ack, HOLD with ready).
- Op remains at last value while op_valid=0 (no clearing).
- Redirect (priority over all except rst): any state -> pc<=redirect_addr, op_valid<=0, counter<=0, -> IDLE. Ack in the same cycle: mem_rdata discarded, pc not incremented. op_ready in same HOLD cycle: handshake still counts as accepted by decode; fetch unit simply drops op_valid. fetch_err not raised if timeout and redirect coincide.
- mem_req always drops for at least one cycle (IDLE or HOLD) between transactions.

Optional Feature:
OPCODE_CHECK_EN. Defined: on capture, if mem_rdata[31:27] > 15 (undefined opcode), op<=32'h0 (NOP) and illegal_op=1 for one cycle with op_valid rise; pc advances normally. Not defined: mem_rdata passed unmodified, illegal_op tied 0.

Test Plan:
- rst 2 cycles, memory acks in first REQ cycle with 32'h1000_8000, op_ready=1 -> mem_addr=0x00 cycle 1 after reset, op=32'h1000_8000 op_valid next cycle, pc=0x01; next mem_req with mem_addr=0x01.
- op_ready=0 for 5 cycles in HOLD -> op and op_valid stable, mem_req=0 throughout; ready=1 -> REQ the following cycle.
- redirect=1, redirect_addr=0x40 in REQ coincident with mem_ack -> data discarded, op_valid stays 0, one IDLE cycle, next mem_addr=0x40.
- ACK_TIMEOUT=4, memory never acks -> fetch_err pulse after 4 REQ cycles, one IDLE cycle, retry same address; ack on retry delivers word.
- pc=0xFF fetch acked -> pc=0x00, next mem_addr=0x00.
- With OPCODE_CHECK_EN, mem_rdata=32'h8800_0000 (opcode 17) -> op=0, illegal_op one-cycle pulse, pc+1; without macro op=32'h8800_0000, illegal_op=0.
